// File: rtl/bucket_head_lookup.sv
// Bucket head lookup: hashed command in, head-RAM read, coherent task out.
// Also serves head-table writes from the insert/delete engines and runs
// the head-RAM clear walk.

package hash_table;
    localparam int KEY_WIDTH      = 32;
    localparam int VALUE_WIDTH    = 32;
    localparam int BUCKET_WIDTH   = 10;
    localparam int HEAD_PTR_WIDTH = 16;

    typedef enum logic [1:0] {
        CMD_SEARCH = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2
    } ht_cmd_t;
endpackage

module bucket_head_lookup #(
    parameter int KEY_WIDTH      = hash_table::KEY_WIDTH,
    parameter int VALUE_WIDTH    = hash_table::VALUE_WIDTH,
    parameter int BUCKET_WIDTH   = hash_table::BUCKET_WIDTH,
    parameter int HEAD_PTR_WIDTH = hash_table::HEAD_PTR_WIDTH,
    parameter int RAM_LATENCY    = 2,
    parameter int OUT_SLOTS      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [KEY_WIDTH-1:0]      cmd_key_i,
    input  logic [VALUE_WIDTH-1:0]    cmd_value_i,
    input  logic [1:0]                cmd_cmd_i,
    input  logic [BUCKET_WIDTH-1:0]   cmd_bucket_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    output logic [KEY_WIDTH-1:0]      task_key_o,
    output logic [VALUE_WIDTH-1:0]    task_value_o,
    output logic [1:0]                task_cmd_o,
    output logic [BUCKET_WIDTH-1:0]   task_bucket_o,
    output logic [HEAD_PTR_WIDTH-1:0] task_head_ptr_o,
    output logic                      task_head_ptr_val_o,
    output logic                      task_valid_o,
    input  logic                      task_ready_i,
    input  logic [BUCKET_WIDTH-1:0]   ht_wr_addr_i,
    input  logic [HEAD_PTR_WIDTH-1:0] ht_wr_data_ptr_i,
    input  logic                      ht_wr_data_ptr_val_i,
    input  logic                      ht_wr_en_i,
    input  logic                      clear_ram_run_i,
    output logic                      clear_ram_done_o
);

    // Stage 0 holds the registered command (RAM addressed from it); the last
    // stage lines up with the RAM output register.
    localparam int STAGES = RAM_LATENCY + 1;
    localparam int CNT_W  = $clog2(OUT_SLOTS + STAGES + 1);
    localparam int HEAD_W = HEAD_PTR_WIDTH + 1;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]      key;
        logic [VALUE_WIDTH-1:0]    value;
        logic [1:0]                cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic                      ovr;
        logic                      ovr_val;
        logic [HEAD_PTR_WIDTH-1:0] ovr_ptr;
    } pipe_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]      key;
        logic [VALUE_WIDTH-1:0]    value;
        logic [1:0]                cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic                      ptr_val;
        logic [HEAD_PTR_WIDTH-1:0] ptr;
    } slot_t;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} clr_state_t;

    clr_state_t              clr_state_q, clr_state_d;
    logic [BUCKET_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                    clr_we;
    logic                    clearing;
    logic                    wr_en;

    logic [HEAD_W-1:0]       mem [2**BUCKET_WIDTH];
    logic [HEAD_W-1:0]       rd_q [RAM_LATENCY];

    pipe_t                   pipe_q [STAGES];
    pipe_t                   pipe_d [STAGES];
    pipe_t                   pipe_in;
    logic [STAGES-1:0]       vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0]        pipe_cnt;

    slot_t                   slot_q [OUT_SLOTS];
    slot_t                   slot_d [OUT_SLOTS];
    slot_t                   slot_p [OUT_SLOTS];
    slot_t                   push_e;
    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d, cnt_tmp;
    logic                    accept, push, pop;
    pipe_t                   ret;

    // Apply a matching head-table write to an in-flight entry's override.
    function automatic pipe_t patch_pipe(input pipe_t e, input logic we,
                                         input logic [BUCKET_WIDTH-1:0] a,
                                         input logic v,
                                         input logic [HEAD_PTR_WIDTH-1:0] p);
        pipe_t r;
        r = e;
        if (we && e.bucket == a) begin
            r.ovr     = 1'b1;
            r.ovr_val = v;
            r.ovr_ptr = p;
        end
        return r;
    endfunction

    assign clearing = (clr_state_q != S_IDLE);
    assign wr_en    = ht_wr_en_i && (clr_state_q != S_CLEAR);

    // Count in-flight reads for the credit check.
    always_comb begin
        pipe_cnt = '0;
        for (int k = 0; k < STAGES; k++) pipe_cnt = pipe_cnt + CNT_W'(vld_pipe_q[k]);
    end

    // Every in-flight entry owns a slot, so the read pipeline never stalls.
    assign cmd_ready_o = !rst_i && !clearing && ((pipe_cnt + slot_cnt_q) < CNT_W'(OUT_SLOTS));
    assign accept      = cmd_valid_i && cmd_ready_o;

    // Clear walk next-state and done pulse.
    always_comb begin
        clr_state_d      = clr_state_q;
        clr_addr_d       = clr_addr_q;
        clr_we           = 1'b0;
        clear_ram_done_o = 1'b0;
        case (clr_state_q)
            S_IDLE: begin
                if (clear_ram_run_i) begin
                    clr_state_d = S_CLEAR;
                    clr_addr_d  = '0;
                end
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                if (clear_ram_run_i)     clr_addr_d  = '0;
                else if (&clr_addr_q)    clr_state_d = S_DONE;
                else                     clr_addr_d  = clr_addr_q + 1'b1;
            end
            S_DONE: begin
                clear_ram_done_o = 1'b1;
                clr_state_d      = S_IDLE;
            end
            default: clr_state_d = S_IDLE;
        endcase
    end

    // Head RAM: clear walk wins over engine writes; registered read pipeline.
    always_ff @(posedge clk_i) begin
        if (clr_we)     mem[clr_addr_q]   <= '0;
        else if (wr_en) mem[ht_wr_addr_i] <= {ht_wr_data_ptr_val_i, ht_wr_data_ptr_i};
        rd_q[0] <= mem[pipe_q[0].bucket];
        for (int k = 1; k < RAM_LATENCY; k++) rd_q[k] <= rd_q[k-1];
    end

    // Advance the read pipeline, snooping head-table writes at every stage.
    always_comb begin
        pipe_in        = '0;
        pipe_in.key    = cmd_key_i;
        pipe_in.value  = cmd_value_i;
        pipe_in.cmd    = cmd_cmd_i;
        pipe_in.bucket = cmd_bucket_i;
        pipe_d[0] = patch_pipe(pipe_in, wr_en, ht_wr_addr_i, ht_wr_data_ptr_val_i, ht_wr_data_ptr_i);
        for (int k = 1; k < STAGES; k++)
            pipe_d[k] = patch_pipe(pipe_q[k-1], wr_en, ht_wr_addr_i,
                                   ht_wr_data_ptr_val_i, ht_wr_data_ptr_i);
        vld_pipe_d = {vld_pipe_q[STAGES-2:0], accept};
    end

    // Build the entry returning from RAM; a snooped write beats RAM data,
    // which may be stale from a read-during-write.
    always_comb begin
        ret            = pipe_q[STAGES-1];
        push           = vld_pipe_q[STAGES-1];
        push_e.key     = ret.key;
        push_e.value   = ret.value;
        push_e.cmd     = ret.cmd;
        push_e.bucket  = ret.bucket;
        {push_e.ptr_val, push_e.ptr} = ret.ovr ? {ret.ovr_val, ret.ovr_ptr} : rd_q[RAM_LATENCY-1];
        if (wr_en && ret.bucket == ht_wr_addr_i) begin
            push_e.ptr_val = ht_wr_data_ptr_val_i;
            push_e.ptr     = ht_wr_data_ptr_i;
        end
    end

    assign task_valid_o        = (slot_cnt_q != '0);
    assign task_key_o          = slot_q[0].key;
    assign task_value_o        = slot_q[0].value;
    assign task_cmd_o          = slot_q[0].cmd;
    assign task_bucket_o       = slot_q[0].bucket;
    assign task_head_ptr_o     = slot_q[0].ptr;
    assign task_head_ptr_val_o = slot_q[0].ptr_val;
    assign pop                 = task_valid_o && task_ready_i;

    // Slot buffer: patch all slots on a matching write, then pop/push in order.
    always_comb begin
        slot_p = slot_q;
        for (int i = 0; i < OUT_SLOTS; i++) begin
            if (wr_en && slot_q[i].bucket == ht_wr_addr_i) begin
                slot_p[i].ptr_val = ht_wr_data_ptr_val_i;
                slot_p[i].ptr     = ht_wr_data_ptr_i;
            end
        end
        slot_d  = slot_p;
        cnt_tmp = slot_cnt_q;
        if (pop) begin
            for (int i = 0; i < OUT_SLOTS - 1; i++) slot_d[i] = slot_p[i+1];
            cnt_tmp = slot_cnt_q - 1'b1;
        end
        if (push) begin
            for (int i = 0; i < OUT_SLOTS; i++)
                if (CNT_W'(i) == cnt_tmp) slot_d[i] = push_e;
        end
        slot_cnt_d = push ? cnt_tmp + 1'b1 : cnt_tmp;
    end

    // State registers; reset drops the walk, in-flight reads and all slots.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_state_q <= S_IDLE;
            clr_addr_q  <= '0;
            vld_pipe_q  <= '0;
            slot_cnt_q  <= '0;
            for (int k = 0; k < STAGES; k++)    pipe_q[k] <= '0;
            for (int i = 0; i < OUT_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_addr_q  <= clr_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            slot_cnt_q  <= slot_cnt_d;
            for (int k = 0; k < STAGES; k++)    pipe_q[k] <= pipe_d[k];
            for (int i = 0; i < OUT_SLOTS; i++) slot_q[i] <= slot_d[i];
        end
    end

endmodule
